// File: rtl/io_bus_responder.sv
// Data-bus responder: splits CPU loads/stores between external DRAM and an IO page
// holding switches, LEDs, a scanned 8-digit 7-segment display and a free-running timer.
module io_bus_responder #(
    parameter logic [31:0] IO_BASE  = 32'hFFFF_F000,
    parameter int          SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dram_we,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);
    localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    // Word offsets within the IO page (byte offset >> 2).
    localparam logic [9:0] OFS_SEG   = 10'h000;
    localparam logic [9:0] OFS_TIMER = 10'h008;
    localparam logic [9:0] OFS_LED   = 10'h018;
    localparam logic [9:0] OFS_SW    = 10'h01C;

    logic          is_io;
    logic          sel_seg, sel_timer, sel_led, sel_sw;
    logic [31:0]   seg_reg;
    logic [31:0]   timer;
    logic [23:0]   sw_meta, sw_sync;
    logic [DW-1:0] div_cnt;
    logic [2:0]    dig_idx;
    logic [3:0]    cur_nib;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    assign is_io     = (addr[31:12] == IO_BASE[31:12]);
    assign sel_seg   = is_io && (addr[11:2] == OFS_SEG);
    assign sel_timer = is_io && (addr[11:2] == OFS_TIMER);
    assign sel_led   = is_io && (addr[11:2] == OFS_LED);
    assign sel_sw    = is_io && (addr[11:2] == OFS_SW);

    assign ram_we    = dram_we & ~is_io;
    assign ram_addr  = addr;
    assign ram_wdata = write_data;

    // Combinational load path so the core's load finishes in its own cycle.
    always_comb begin
        read_data = 32'h0;
        if (!is_io)         read_data = ram_rdata;
        else if (sel_seg)   read_data = seg_reg;
        else if (sel_timer) read_data = timer;
        else if (sel_led)   read_data = {8'h0, led};
        else if (sel_sw)    read_data = {8'h0, sw_sync};
    end

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;  4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
            4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
            4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
        endcase
    endfunction

    assign cur_nib = seg_reg[{dig_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= 24'h0;
            seg_reg <= 32'h0;
            timer   <= 32'h0;
            sw_meta <= 24'h0;
            sw_sync <= 24'h0;
            div_cnt <= '0;
            dig_idx <= 3'd0;
            dig_en  <= 8'hFE;
            seg     <= 8'h03;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;

            if (dram_we && sel_led) led <= write_data[23:0];
            if (dram_we && sel_seg) seg_reg <= write_data;
            // A timer store overrides that cycle's increment.
            if (dram_we && sel_timer) timer <= write_data;
            else                      timer <= timer + 32'd1;

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                dig_idx <= dig_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            dig_en <= ~(8'b1 << dig_idx);
            seg    <= seg7(cur_nib);
        end
    end
endmodule

// File: tb/tb_io_bus_responder.sv
// Scoreboard bench for io_bus_responder: stimulus queues expected observations tagged
// with the cycle they are due; a negedge monitor pops and compares them.
module tb_io_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dram_we;
    logic [31:0] addr, write_data, read_data, ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic [23:0] sw, led;
    logic [7:0]  dig_en, seg;

    io_bus_responder #(.IO_BASE(32'hFFFF_F000), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .dram_we(dram_we), .addr(addr),
        .write_data(write_data), .read_data(read_data), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .sw(sw), .led(led), .dig_en(dig_en), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef enum int {K_RD, K_WE, K_RADDR, K_WDATA, K_LED, K_DIG, K_SEG} kind_t;
    typedef struct {
        int          due;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    checks = 0;
    int    passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(kind_t k);
        case (k)
            K_RD:    observe = read_data;
            K_WE:    observe = {31'h0, ram_we};
            K_RADDR: observe = ram_addr;
            K_WDATA: observe = ram_wdata;
            K_LED:   observe = {8'h0, led};
            K_DIG:   observe = {24'h0, dig_en};
            default: observe = {24'h0, seg};
        endcase
    endfunction

    // Monitor: consume everything due in the current cycle, flag anything overdue.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            item_t it;
            logic [31:0] act;
            it  = sb.pop_front();
            act = observe(it.kind);
            checks++;
            if (it.due < cyc)
                $display("FAIL %s: missed sample (due cycle %0d, now %0d)", it.name, it.due, cyc);
            else if (act !== it.exp)
                $display("FAIL %s: got %h expected %h (cycle %0d)", it.name, act, it.exp, cyc);
            else
                passed++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(kind_t k, logic [31:0] v, string nm);
        item_t it;
        it.due  = cyc;
        it.kind = k;
        it.exp  = v;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic bus(logic we, logic [31:0] a, logic [31:0] wd);
        dram_we    = we;
        addr       = a;
        write_data = wd;
    endtask

    function automatic logic [7:0] seg_for(int digit);
        // SEG holds 0x0000_00F1: digit 0 = '1', digit 1 = 'F', the rest '0'.
        if (digit == 0)      seg_for = 8'h9F;
        else if (digit == 1) seg_for = 8'h71;
        else                 seg_for = 8'h03;
    endfunction

    initial begin
        int k;
        rst_n = 1'b0;
        bus(1'b0, 32'h0, 32'h0);
        ram_rdata = 32'h0;
        sw        = 24'h0;

        // Reset state.
        step();
        step();
        bus(1'b0, 32'hFFFF_F020, 32'h0);
        expect_val(K_DIG, 32'hFE, "rst_dig_en");
        expect_val(K_SEG, 32'h03, "rst_seg");
        expect_val(K_LED, 32'h0,  "rst_led");
        expect_val(K_RD,  32'h0,  "rst_timer");
        step();
        bus(1'b0, 32'hFFFF_F070, 32'h0);
        expect_val(K_RD,  32'h0,  "rst_sw");

        // Release reset and write SEG in the same window; scan starts at digit 0.
        step();
        rst_n = 1'b1;
        bus(1'b1, 32'hFFFF_F000, 32'h0000_00F1);
        expect_val(K_WE, 32'h0, "seg_wr_no_ram_we");
        expect_val(K_RD, 32'h0, "seg_wr_reads_old");
        step();                               // after edge 1
        bus(1'b0, 32'hFFFF_F000, 32'h0);
        expect_val(K_DIG, 32'hFE, "scan_e1_dig");
        expect_val(K_SEG, 32'h03, "scan_e1_seg_old");
        expect_val(K_RD,  32'hF1, "seg_readback");
        for (int n = 2; n <= 34; n++) begin   // after edge n, digit (n-1)/4 mod 8 lit
            step();
            k = ((n - 1) / 4) % 8;
            if ((n % 4) == 1 || n == 2) begin
                expect_val(K_DIG, {24'h0, ~(8'b1 << k)}, $sformatf("scan_e%0d_dig", n));
                expect_val(K_SEG, {24'h0, seg_for(k)},   $sformatf("scan_e%0d_seg", n));
            end
        end

        // DRAM store and loads.
        step();
        ram_rdata = 32'hCAFE_0001;
        bus(1'b1, 32'h0000_0100, 32'h0000_1234);
        expect_val(K_WE,    32'h1,         "dram_we");
        expect_val(K_RADDR, 32'h100,       "dram_addr");
        expect_val(K_WDATA, 32'h0000_1234, "dram_wdata");
        expect_val(K_RD,    32'hCAFE_0001, "dram_rd");
        step();
        ram_rdata = 32'h5555_AAAA;
        bus(1'b0, 32'h0000_0100, 32'h0);
        expect_val(K_WE, 32'h0,         "dram_load_we");
        expect_val(K_RD, 32'h5555_AAAA, "dram_load");
        step();
        bus(1'b1, 32'hFFFF_EFFC, 32'h1);       // just below the IO page
        expect_val(K_WE, 32'h1,         "below_io_we");
        expect_val(K_RD, 32'h5555_AAAA, "below_io_rd");

        // LED.
        step();
        bus(1'b1, 32'hFFFF_F060, 32'hFFAB_CDEF);
        expect_val(K_WE, 32'h0, "led_wr_no_ram_we");
        expect_val(K_RD, 32'h0, "led_same_cycle_old");
        step();
        bus(1'b0, 32'hFFFF_F060, 32'h0);
        expect_val(K_LED, 32'h00AB_CDEF, "led_out");
        expect_val(K_RD,  32'h00AB_CDEF, "led_read");

        // Switch synchroniser and read-only behaviour.
        step();
        sw = 24'h0000A5;
        bus(1'b0, 32'hFFFF_F070, 32'h0);
        expect_val(K_RD, 32'h0, "sw_edge0");
        step();
        expect_val(K_RD, 32'h0, "sw_edge1");
        step();
        expect_val(K_RD, 32'h0000_00A5, "sw_edge2");
        bus(1'b1, 32'hFFFF_F070, 32'hFFFF_FFFF);
        expect_val(K_WE, 32'h0, "sw_wr_no_ram_we");
        step();
        bus(1'b0, 32'hFFFF_F070, 32'h0);
        expect_val(K_RD,  32'h0000_00A5, "sw_wr_ignored");
        expect_val(K_LED, 32'h00AB_CDEF, "sw_wr_led_kept");

        // Unmapped offset: read 0, store goes nowhere.
        step();
        bus(1'b1, 32'hFFFF_F044, 32'h1234_5678);
        expect_val(K_WE, 32'h0, "unmapped_we");
        expect_val(K_RD, 32'h0, "unmapped_rd");

        // Timer load and wrap.
        step();
        bus(1'b1, 32'hFFFF_F020, 32'hFFFF_FFFE);
        step();
        bus(1'b0, 32'hFFFF_F020, 32'h0);
        expect_val(K_RD, 32'hFFFF_FFFE, "timer_load");
        step();
        expect_val(K_RD, 32'hFFFF_FFFF, "timer_inc");
        step();
        expect_val(K_RD, 32'h0, "timer_wrap");
        step();
        expect_val(K_RD, 32'h1, "timer_after_wrap");

        // Asynchronous reset mid-scan with state nonzero.
        step();
        step();
        bus(1'b0, 32'hFFFF_F044, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        expect_val(K_RD,  32'h0,  "arst_unmapped");
        expect_val(K_LED, 32'h0,  "arst_led");
        expect_val(K_DIG, 32'hFE, "arst_dig_en");
        expect_val(K_SEG, 32'h03, "arst_seg");
        step();
        bus(1'b0, 32'hFFFF_F020, 32'h0);
        expect_val(K_RD, 32'h0, "arst_timer");
        step();
        bus(1'b1, 32'h0000_0200, 32'h0);
        expect_val(K_WE, 32'h1, "arst_ram_we_decode");
        step();
        bus(1'b0, 32'hFFFF_F000, 32'h0);
        expect_val(K_RD, 32'h0, "arst_seg_reg");

        // Drain scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d items left, expected 0", sb.size());
            checks += sb.size();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
